// File: rtl/tick_period_meter.sv
// Measures the period of a single-cycle tick stream in clk cycles and offers each
// completed period on a valid/ready port, with lock, timeout and overrun flags.
module tick_period_meter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         tick,
    input  logic         period_ready,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

    // Last counter value before the period would exceed 2^W-1.
    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           have_prev_q, have_prev_d;
    logic           period_valid_q, period_valid_d;
    logic           locked_q, locked_d;
    logic           timeout_q, timeout_d;
    logic           overrun_q, overrun_d;
    logic           result;
    logic [W-1:0]   res_val;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
        period_valid_d = period_valid_q;
        locked_d       = locked_q;
        timeout_d      = timeout_q;
        overrun_d      = overrun_q;
        result         = 1'b0;
        res_val        = cnt_q + W'(1);

        if (!en) begin
            // A tick in the cycle en falls is dropped; period/valid keep draining.
            state_d     = IDLE;
            cnt_d       = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
            overrun_d   = 1'b0;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
                ARMED: begin
                    if (tick) begin
                        state_d   = MEASURE;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (tick) begin
                        result    = 1'b1;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Tick lost: next tick re-arms without emitting a result.
                        state_d     = ARMED;
                        cnt_d       = '0;
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        have_prev_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (result) begin
            period_d       = res_val;
            period_valid_d = 1'b1;
            locked_d       = have_prev_q && (res_val == prev_q);
            prev_d         = res_val;
            have_prev_d    = 1'b1;
            if (period_valid_q && !period_ready)
                overrun_d = 1'b1;
        end else if (period_valid_q && period_ready) begin
            period_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            prev_q         <= '0;
            have_prev_q    <= 1'b0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
            overrun_q      <= overrun_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule
